// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller with priority arbitration, valid/ready claim and a nesting stack.
// Offer appears two edges after a pending set; the offer is held without change until irq_ready_i is seen.
module irq_ctrl #(
  parameter int unsigned NrIrqs    = 32,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned NestDepth = 4,
  localparam int unsigned IdxWidth = $clog2(NrIrqs)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NrIrqs-1:0]    irq_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [PrioWidth-1:0] cfg_prio_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_pend_i,
  output logic                 irq_valid_o,
  input  logic                 irq_ready_i,
  output logic [IdxWidth-1:0]  irq_id_o,
  output logic [PrioWidth-1:0] irq_prio_o,
  input  logic                 irq_complete_i,
  output logic [PrioWidth-1:0] level_o
);

  localparam int unsigned DepthW = $clog2(NestDepth + 1);

  typedef struct packed {
    logic                 vld;
    logic [IdxWidth-1:0]  idx;
    logic [PrioWidth-1:0] prio;
  } arb_t;

  typedef enum logic [1:0] {IDLE, OFFER, FLUSH} state_e;

  logic [NrIrqs-1:0]    irq_prev_q, irq_prev_d;
  logic [NrIrqs-1:0]    pend_q, pend_d;
  logic [NrIrqs-1:0]    en_q, en_d;
  logic [PrioWidth-1:0] line_prio_q [NrIrqs];
  logic [PrioWidth-1:0] line_prio_d [NrIrqs];
  arb_t                 arb_q, arb_d;
  state_e               state_q, state_d;
  logic [IdxWidth-1:0]  off_id_q, off_id_d;
  logic [PrioWidth-1:0] off_prio_q, off_prio_d;
  logic [PrioWidth-1:0] stk_q [NestDepth];
  logic [PrioWidth-1:0] stk_d [NestDepth];
  logic [DepthW-1:0]    depth_q, depth_d;

  logic [NrIrqs-1:0]    set_vec;
  logic                 hs;
  logic                 pop;
  logic                 full;
  logic [DepthW-1:0]    depth_pop;
  logic [PrioWidth-1:0] level;

  always_comb begin
    set_vec     = irq_i & ~irq_prev_q;
    irq_prev_d  = irq_i;
    hs          = (state_q == OFFER) && irq_ready_i;
    pend_d      = pend_q;
    en_d        = en_q;
    line_prio_d = line_prio_q;
    for (int n = 0; n < NrIrqs; n++) begin
      if (cfg_we_i && cfg_idx_i == IdxWidth'(n)) begin
        en_d[n]        = cfg_en_i;
        line_prio_d[n] = cfg_prio_i;
        if (cfg_pend_i) set_vec[n] = 1'b1;
      end
      if (hs && off_id_q == IdxWidth'(n)) pend_d[n] = 1'b0;
    end
    // A fresh set in the claim cycle must survive the clear.
    pend_d = pend_d | set_vec;

    // Strict '>' while scanning upward keeps the lower index on a tie.
    arb_d = '0;
    for (int n = 0; n < NrIrqs; n++) begin
      if (pend_q[n] && en_q[n] && (!arb_d.vld || line_prio_q[n] > arb_d.prio)) begin
        arb_d.vld  = 1'b1;
        arb_d.idx  = IdxWidth'(n);
        arb_d.prio = line_prio_q[n];
      end
    end

    level = '0;
    for (int i = 0; i < NestDepth; i++) begin
      if (depth_q == DepthW'(i + 1)) level = stk_q[i];
    end
    full = (depth_q == DepthW'(NestDepth));

    // Pop happens before push so a same-edge claim and complete replaces the top.
    pop       = irq_complete_i && (depth_q != '0);
    depth_pop = depth_q - DepthW'(pop);
    stk_d     = stk_q;
    depth_d   = depth_pop;
    if (hs) begin
      for (int i = 0; i < NestDepth; i++) begin
        if (depth_pop == DepthW'(i)) stk_d[i] = off_prio_q;
      end
      depth_d = depth_pop + DepthW'(1);
    end

    state_d    = state_q;
    off_id_d   = off_id_q;
    off_prio_d = off_prio_q;
    case (state_q)
      IDLE: begin
        if (arb_q.vld && arb_q.prio > level && !full) begin
          state_d    = OFFER;
          off_id_d   = arb_q.idx;
          off_prio_d = arb_q.prio;
        end
      end
      OFFER:   if (irq_ready_i) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_prev_q  <= '0;
      pend_q      <= '0;
      en_q        <= '0;
      line_prio_q <= '{default: '0};
      arb_q       <= '0;
      state_q     <= IDLE;
      off_id_q    <= '0;
      off_prio_q  <= '0;
      stk_q       <= '{default: '0};
      depth_q     <= '0;
    end else begin
      irq_prev_q  <= irq_prev_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      line_prio_q <= line_prio_d;
      arb_q       <= arb_d;
      state_q     <= state_d;
      off_id_q    <= off_id_d;
      off_prio_q  <= off_prio_d;
      stk_q       <= stk_d;
      depth_q     <= depth_d;
    end
  end

  assign irq_valid_o = (state_q == OFFER);
  assign irq_id_o    = off_id_q;
  assign irq_prio_o  = off_prio_q;
  assign level_o     = level;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: cycle table for the basic flows, hand sequences for nesting, stalls and reset.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq = '0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_idx = '0;
  logic [7:0]  cfg_prio = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_pend = 1'b0;
  logic        rdy = 1'b0;
  logic        cmp = 1'b0;
  logic        vld;
  logic [4:0]  id;
  logic [7:0]  prio;
  logic [7:0]  lvl;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .irq_i          (irq),
    .cfg_we_i       (cfg_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_prio_i     (cfg_prio),
    .cfg_en_i       (cfg_en),
    .cfg_pend_i     (cfg_pend),
    .irq_valid_o    (vld),
    .irq_ready_i    (rdy),
    .irq_id_o       (id),
    .irq_prio_o     (prio),
    .irq_complete_i (cmp),
    .level_o        (lvl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] irq;
    logic        we;
    logic [4:0]  idx;
    logic [7:0]  prio;
    logic        en;
    logic        pend;
    logic        rdy;
    logic        cmp;
    logic        e_vld;
    logic [4:0]  e_id;
    logic [7:0]  e_prio;
    logic [7:0]  e_lvl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] i, input logic w, input logic [4:0] x, input logic [7:0] p,
                     input logic e, input logic pd, input logic r, input logic c,
                     input logic ev, input logic [4:0] eid, input logic [7:0] ep, input logic [7:0] el);
    vec_t v;
    v = '{irq: i, we: w, idx: x, prio: p, en: e, pend: pd, rdy: r, cmp: c,
          e_vld: ev, e_id: eid, e_prio: ep, e_lvl: el};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int x, input int p, input logic e, input logic pd);
    cfg_we = 1'b1; cfg_idx = 5'(x); cfg_prio = 8'(p); cfg_en = e; cfg_pend = pd;
    cyc();
    cfg_we = 1'b0; cfg_pend = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!vld && n < 10) begin
      cyc();
      n++;
    end
    chk(name, 32'(vld), 1);
  endtask

  task automatic claim();
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
  endtask

  task automatic complete();
    cmp = 1'b1;
    cyc();
    cmp = 1'b0;
  endtask

  initial begin
    logic saw;
    logic bad;

    // Single line, two lines at equal priority, then a nested preemption.
    add(32'h0,  1, 5, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    add(32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 1, 5, 3, 0);
    add(32'h0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(32'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(32'h0,  1, 2, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    add(32'h0,  1, 9, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0);
    add(32'h0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(32'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 1, 9, 4, 0);
    add(32'h0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4);
    add(32'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h0,  1, 7, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    add(32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 1, 5, 3, 0);
    add(32'h0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
    add(32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 1, 7, 6, 3);
    add(32'h0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6);
    add(32'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
    add(32'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    #1;
    chk("reset.valid", 32'(vld), 0);
    chk("reset.id", 32'(id), 0);
    chk("reset.prio", 32'(prio), 0);
    chk("reset.level", 32'(lvl), 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    foreach (tbl[i]) begin
      irq = tbl[i].irq; cfg_we = tbl[i].we; cfg_idx = tbl[i].idx; cfg_prio = tbl[i].prio;
      cfg_en = tbl[i].en; cfg_pend = tbl[i].pend; rdy = tbl[i].rdy; cmp = tbl[i].cmp;
      cyc();
      chk($sformatf("vec%0d.valid", i), 32'(vld), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d.level", i), 32'(lvl), 32'(tbl[i].e_lvl));
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d.id", i), 32'(id), 32'(tbl[i].e_id));
        chk($sformatf("vec%0d.prio", i), 32'(prio), 32'(tbl[i].e_prio));
      end
    end
    irq = '0; cfg_we = 1'b0; cfg_pend = 1'b0; rdy = 1'b0; cmp = 1'b0;

    // Fill the nesting stack with priorities 1..4, then a prio 9 line must wait for a pop.
    for (int p = 1; p <= 4; p++) begin
      cfg(9 + p, p, 1'b1, 1'b1);
      wait_valid($sformatf("nest%0d.offer", p));
      chk($sformatf("nest%0d.id", p), 32'(id), 32'(9 + p));
      claim();
      chk($sformatf("nest%0d.level", p), 32'(lvl), 32'(p));
    end
    cfg(14, 9, 1'b1, 1'b1);
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (vld) saw = 1'b1;
    end
    chk("full.no_offer", 32'(saw), 0);
    complete();
    chk("full.pop_level", 32'(lvl), 3);
    wait_valid("full.resume");
    chk("full.resume_id", 32'(id), 14);
    chk("full.resume_prio", 32'(prio), 9);
    claim();
    chk("full.level9", 32'(lvl), 9);
    repeat (4) complete();
    chk("full.drained", 32'(lvl), 0);

    // Stalled offer stays put while a higher line arrives; claim+complete on one edge.
    cfg(22, 2, 1'b1, 1'b1);
    wait_valid("stall.pre_offer");
    claim();
    chk("stall.level2", 32'(lvl), 2);
    cfg(20, 5, 1'b1, 1'b1);
    wait_valid("stall.offer");
    chk("stall.id", 32'(id), 20);
    cfg(21, 7, 1'b1, 1'b1);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!vld || id != 5'd20 || prio != 8'd5) bad = 1'b1;
      cyc();
    end
    chk("stall.stable", 32'(bad), 0);
    rdy = 1'b1; cmp = 1'b1;
    cyc();
    rdy = 1'b0; cmp = 1'b0;
    chk("stall.swap_level", 32'(lvl), 5);
    complete();
    chk("stall.depth_one", 32'(lvl), 0);
    wait_valid("stall.next");
    chk("stall.next_id", 32'(id), 21);
    chk("stall.next_prio", 32'(prio), 7);
    claim();
    complete();

    // Reset while offering drops the offer and the stack at once.
    cfg(22, 2, 1'b1, 1'b1);
    wait_valid("rst.pre_offer");
    claim();
    cfg(5, 3, 1'b1, 1'b1);
    wait_valid("rst.offer");
    chk("rst.offer_id", 32'(id), 5);
    rst_n = 1'b0;
    #1;
    chk("rst.valid_drop", 32'(vld), 0);
    chk("rst.level_drop", 32'(lvl), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cfg(5, 3, 1'b1, 1'b0);
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (vld) saw = 1'b1;
    end
    chk("rst.pending_lost", 32'(saw), 0);
    irq = 32'h20;
    cyc();
    irq = '0;
    wait_valid("rst.new_edge");
    chk("rst.new_id", 32'(id), 5);
    claim();
    chk("rst.new_level", 32'(lvl), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NrIrqs, 32, number of interrupt lines; power of two, >= 2.
REQ-002 Parameter PrioWidth, 8, priority field width.
REQ-003 Parameter NestDepth, 4, maximum number of nested in-service interrupts; >= 1.
REQ-004 Localparam IdxWidth = $clog2(NrIrqs).
REQ-005 Port clk_i  in  1  clock; one clock domain, all state on its rising edge.
REQ-006 Port rst_ni  in  1  reset; asynchronous, active-low.
REQ-007 Port irq_i  in  NrIrqs  interrupt lines, synchronous to clk_i, rising-edge sensitive.
REQ-008 Port cfg_we_i  in  1  configuration write strobe, one line per cycle.
REQ-009 Port cfg_idx_i  in  IdxWidth  line selected by the write.
REQ-010 Port cfg_prio_i  in  PrioWidth  priority written to that line.
REQ-011 Port cfg_en_i  in  1  enable written to that line.
REQ-012 Port cfg_pend_i  in  1  when 1 with cfg_we_i, software-sets pending of that line.
REQ-013 Port irq_valid_o  out  1  interrupt offered to core.
REQ-014 Port irq_ready_i  in  1  core accepts offer (claim).
REQ-015 Port irq_id_o  out  IdxWidth  offered line index.
REQ-016 Port irq_prio_o  out  PrioWidth  offered priority.
REQ-017 Port irq_complete_i  in  1  core finished the innermost in-service interrupt.
REQ-018 Port level_o  out  PrioWidth  current threshold (top of nesting stack, 0 when empty).

Function
REQ-019 pending[n] shall set on the edge after irq_i[n] is sampled 1 while its registered previous value was 0, or on a cfg write with cfg_pend_i=1.
REQ-020 pending[n] shall clear on the edge on which irq_valid_o && irq_ready_i with irq_id_o==n; a simultaneous set of the same line shall win.
REQ-021 A cfg write shall update prio[idx] and en[idx] on that edge; pending is unaffected unless cfg_pend_i=1.
REQ-022 Arbitration input per line: valid = pending & en, priority = prio; highest priority wins; equal priority goes to the lower index.
REQ-023 The arbitration result {valid, idx, prio} shall be registered every cycle (arb_q); the arbiter tree is combinational.
REQ-024 FSM states: IDLE, OFFER, FLUSH; reset state IDLE.
REQ-025 IDLE->OFFER when arb_q.valid && arb_q.prio > level_o && stack not full; offer registers capture arb_q.idx/prio on that edge.
REQ-026 irq_valid_o shall be 1 exactly in OFFER; irq_id_o/irq_prio_o shall remain stable until handshake, and the offer is never withdrawn.
REQ-027 OFFER->FLUSH on irq_valid_o && irq_ready_i: push irq_prio_o onto stack, clear pending; OFFER holds otherwise.
REQ-028 FLUSH->IDLE unconditionally after one cycle, so arb_q reflects the cleared pending.
REQ-029 Latency: irq_i rising sampled at edge k -> pending after k -> arb_q after k+1 -> irq_valid_o=1 after k+2 (from IDLE, line winning, above threshold).
REQ-030 irq_complete_i shall pop the stack in any state; pop on empty stack is ignored.
REQ-031 Handshake and complete on the same edge: pop then push, depth unchanged, top = new prio.
REQ-032 Stack full (depth == NestDepth): no new offer; resumes after a pop.
REQ-033 Priority 0 lines are never offered (0 is never > level_o).
REQ-034 level_o shall be top-of-stack priority, 0 when depth 0.

Reset
REQ-035 On rst_ni low, asynchronously: pending, prio, en, edge registers, arb_q, offer registers, stack and depth = 0; FSM = IDLE; irq_valid_o = 0, irq_id_o = 0, irq_prio_o = 0, level_o = 0.
REQ-036 Reset mid-offer shall drop the offer immediately and lose all pending state.

Verification
REQ-037 Line 5 en, prio 3; pulse irq_i[5] at edge k -> irq_valid_o=1, irq_id_o=5, irq_prio_o=3 after edge k+2; ready -> pending[5]=0, level_o=3.
REQ-038 Lines 2 and 9 both prio 4, pending together -> id 2 offered first; line 9 offered only after complete returns level_o to 0.
REQ-039 Level 3 in service, line 7 prio 6 fires -> offered (nesting), level_o=6; complete -> level_o=3; second complete -> 0.
REQ-040 NestDepth=4, four nested claims prios 1,2,3,4; line prio 9 pending -> irq_valid_o stays 0 until one complete.
REQ-041 Hold irq_ready_i=0 for 10 cycles while higher-prio line fires -> id/prio unchanged; claim and complete same cycle -> depth unchanged.
REQ-042 Assert rst_ni=0 in OFFER -> irq_valid_o=0 same cycle; after release no offer until a new edge.
